move_link_ctrl: RTL
===================

// Module: move_link_ctrl
// PURPOSE
//  Host-side link controller for the game board. Parses opponent-move packets from a byte stream,
//  drives the board's opponent-move inputs (x_1, y_1, x_2, y_2) and its compute_move strobe,
//  waits a fixed think window, then samples the board's reply (x_out, y_out) and serialises it
//  back to the host as a byte packet. Sits between the UART byte layer and game_board.
// PARAMETERS
//  BOARD_SIZE    19   legal coordinate range is 0..BOARD_SIZE-1
//  THINK_CYCLES  64   cycles compute_move is held high before x_out/y_out are sampled (>=1)
//  RX_HDR        8'hA5  opponent-packet header byte
//  TX_HDR        8'h5A  reply-packet header byte
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset_n      in   1   asynchronous active-low reset
//  rx_data      in   8   host byte in
//  rx_valid     in   1   rx_data valid
//  rx_ready     out  1   controller accepts rx_data this cycle
//  tx_data      out  8   reply byte out
//  tx_valid     out  1   tx_data valid
//  tx_ready     in   1   sink accepts tx_data this cycle
//  brd_x1       out  6   opponent stone 1 x, to game_board x_1
//  brd_y1       out  6   opponent stone 1 y, to game_board y_1
//  brd_x2       out  6   opponent stone 2 x, to game_board x_2
//  brd_y2       out  6   opponent stone 2 y, to game_board y_2
//  brd_compute  out  1   to game_board compute_move (0 = place opponent, 1 = compute our move)
//  brd_x_out    in   6   our move x, from game_board x_out
//  brd_y_out    in   6   our move y, from game_board y_out
//  pkt_err      out  1   one-cycle pulse on a dropped packet
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, rx_ready 0, state IDLE. Reset is honoured mid-packet or mid-think;
//   no partial packet survives it.
//  A byte transfers when valid && ready on the same edge.
//   rx_ready=1 only in IDLE/RX_* states.
//   tx_data is held stable while tx_valid=1 && !tx_ready.
//  FSM:
//   IDLE: byte==RX_HDR -> RX_X1; any other byte is consumed and discarded.
//   RX_X1 -> RX_Y1 -> RX_X2 -> RX_Y2 -> PLACE: one byte each.
//    Low 6 bits are stored; bits [7:6] must be 0.
//    Value >= BOARD_SIZE is illegal, except 6'h3F in both X2 and Y2 (single-stone opening turn).
//    An illegal byte pulses pkt_err the next cycle, goes to IDLE and leaves brd_* unchanged.
//  PLACE: brd_x1..brd_y2 are updated from the staging regs. brd_compute=0. Lasts exactly 2 cycles.
//  THINK: brd_compute=1 for exactly THINK_CYCLES cycles (down-counter, reload on entry).
//   On the final cycle, brd_x_out/brd_y_out are registered -> TX_H.
//  TX_H: sends TX_HDR. TX_X: sends {2'b00, x}. TX_Y: sends {2'b00, y}. After TX_Y is accepted:
//   brd_compute returns to 0 and the FSM goes to IDLE.
//  brd_compute is registered and glitch-free; it changes only on PLACE->THINK and on leaving TX_Y.
//  Bytes on rx_* during PLACE/THINK/TX_* are not accepted (rx_ready=0); the host stalls.
//  tx_ready held low indefinitely: the FSM waits in the TX state, with no timeout.
// CONFIGURATION
//  MOVE_LINK_CHECKSUM_EN defined:
//   RX packets carry a 6th byte = XOR of the 5 preceding bytes (RX_CK state after RX_Y2).
//    A mismatch pulses pkt_err, goes to IDLE and leaves brd_* unchanged.
//   Reply gains a 4th byte = TX_HDR^x^y (TX_CK state).
//  Undefined: 5-byte RX packets and 3-byte replies; no checksum states are built.
// TESTING
//  Send A5 03 04 05 06 -> brd_x1..y2 = 3,4,5,6. brd_compute low 2 cycles, then high 64 cycles.
//   With brd_x_out=9, brd_y_out=10, tx emits 5A 09 0A.
//  Send A5 12 00 3F 3F -> accepted (single stone at 18,0), full reply returned.
//   Send A5 13 ... -> pkt_err pulse after the 0x13 byte, brd_* unchanged, FSM back in IDLE.
//  Garbage 00 FF A5 01 01 02 02 -> leading 00 FF discarded, packet accepted normally.
//  Hold tx_ready=0 for 20 cycles during TX_X -> tx_data stays 8'h09 and tx_valid stays 1.
//   Exactly 3 bytes are transferred in total.
//  Assert reset_n=0 during THINK -> brd_compute and all outputs 0 immediately.
//   After release, the FSM is in IDLE and a new packet works.
//  With MOVE_LINK_CHECKSUM_EN: A5 01 02 03 04 A1 -> accepted, reply ends with checksum byte.
//   A5 01 02 03 04 00 -> pkt_err, no reply.

Source files
------------

// File: rtl/move_link_ctrl.sv
// move_link_ctrl: host-side link controller for the game board.
// Parses opponent-move packets from the host byte stream, places them on the
// board, raises compute_move for a fixed think window, then serialises the
// board's reply back to the host.
// Optional feature macro: MOVE_LINK_CHECKSUM_EN (6-byte RX packets with an XOR
// check byte, 4-byte replies with an XOR check byte).
module move_link_ctrl #(
  parameter int         BOARD_SIZE   = 19,
  parameter int         THINK_CYCLES = 64,
  parameter logic [7:0] RX_HDR       = 8'hA5,
  parameter logic [7:0] TX_HDR       = 8'h5A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [5:0] brd_x1,
  output logic [5:0] brd_y1,
  output logic [5:0] brd_x2,
  output logic [5:0] brd_y2,
  output logic       brd_compute,
  input  logic [5:0] brd_x_out,
  input  logic [5:0] brd_y_out,
  output logic       pkt_err,
  output logic       busy
);

  // Counter serves both the 2-cycle PLACE window and the THINK window.
  localparam int             CNT_W      = $clog2(THINK_CYCLES + 2);
  localparam logic [CNT_W-1:0] THINK_LOAD = CNT_W'(THINK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLACE_LOAD = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RX_X1 = 4'd1,
    RX_Y1 = 4'd2,
    RX_X2 = 4'd3,
    RX_Y2 = 4'd4,
    PLACE = 4'd5,
    THINK = 4'd6,
    TX_H  = 4'd7,
    TX_X  = 4'd8,
    TX_Y  = 4'd9
`ifdef MOVE_LINK_CHECKSUM_EN
    ,
    RX_CK = 4'd10,
    TX_CK = 4'd11
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       stg_x1_q, stg_x1_d, stg_y1_q, stg_y1_d;
  logic [5:0]       stg_x2_q, stg_x2_d, stg_y2_q, stg_y2_d;
  logic [5:0]       brd_x1_q, brd_x1_d, brd_y1_q, brd_y1_d;
  logic [5:0]       brd_x2_q, brd_x2_d, brd_y2_q, brd_y2_d;
  logic [5:0]       rep_x_q, rep_x_d, rep_y_q, rep_y_d;
  logic [7:0]       ck_q, ck_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             rx_ready_q, rx_ready_d;
  logic             brd_compute_q, brd_compute_d;
  logic             pkt_err_q, pkt_err_d;
  logic             busy_q, busy_d;
  logic             rx_fire, tx_fire;

  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;

  // A coordinate byte is legal when its top bits are clear and it is on the board.
  function automatic logic coord_ok(input logic [7:0] b);
    return (b[7:6] == 2'b00) && (32'(b[5:0]) < BOARD_SIZE);
  endfunction

  // Next-state and datapath: packet parsing, place/think timing, reply serialisation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stg_x1_d      = stg_x1_q;
    stg_y1_d      = stg_y1_q;
    stg_x2_d      = stg_x2_q;
    stg_y2_d      = stg_y2_q;
    brd_x1_d      = brd_x1_q;
    brd_y1_d      = brd_y1_q;
    brd_x2_d      = brd_x2_q;
    brd_y2_d      = brd_y2_q;
    rep_x_d       = rep_x_q;
    rep_y_d       = rep_y_q;
    ck_d          = ck_q;
    brd_compute_d = brd_compute_q;
    pkt_err_d     = 1'b0;
    case (state_q)
      IDLE: if (rx_fire && rx_data == RX_HDR) begin
        state_d = RX_X1;
        ck_d    = RX_HDR;
      end
      RX_X1: if (rx_fire) begin
        if (coord_ok(rx_data)) begin
          stg_x1_d = rx_data[5:0];
          ck_d     = ck_q ^ rx_data;
          state_d  = RX_Y1;
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RX_Y1: if (rx_fire) begin
        if (coord_ok(rx_data)) begin
          stg_y1_d = rx_data[5:0];
          ck_d     = ck_q ^ rx_data;
          state_d  = RX_X2;
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      // 0x3F is accepted tentatively here; RX_Y2 insists it comes paired.
      RX_X2: if (rx_fire) begin
        if (coord_ok(rx_data) || rx_data == 8'h3F) begin
          stg_x2_d = rx_data[5:0];
          ck_d     = ck_q ^ rx_data;
          state_d  = RX_Y2;
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RX_Y2: if (rx_fire) begin
        if ((stg_x2_q == 6'h3F) ? (rx_data == 8'h3F) : coord_ok(rx_data)) begin
          stg_y2_d = rx_data[5:0];
          ck_d     = ck_q ^ rx_data;
`ifdef MOVE_LINK_CHECKSUM_EN
          state_d  = RX_CK;
`else
          state_d  = PLACE;
          cnt_d    = PLACE_LOAD;
`endif
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
`ifdef MOVE_LINK_CHECKSUM_EN
      RX_CK: if (rx_fire) begin
        if (rx_data == ck_q) begin
          state_d = PLACE;
          cnt_d   = PLACE_LOAD;
        end else begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end
      end
`endif
      PLACE: begin
        brd_x1_d = stg_x1_q;
        brd_y1_d = stg_y1_q;
        brd_x2_d = stg_x2_q;
        brd_y2_d = stg_y2_q;
        if (cnt_q == '0) begin
          state_d       = THINK;
          cnt_d         = THINK_LOAD;
          brd_compute_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      THINK: begin
        if (cnt_q == '0) begin
          rep_x_d = brd_x_out;
          rep_y_d = brd_y_out;
          state_d = TX_H;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      TX_H: if (tx_fire) state_d = TX_X;
      TX_X: if (tx_fire) state_d = TX_Y;
      TX_Y: if (tx_fire) begin
`ifdef MOVE_LINK_CHECKSUM_EN
        state_d       = TX_CK;
`else
        state_d       = IDLE;
        brd_compute_d = 1'b0;
`endif
      end
`ifdef MOVE_LINK_CHECKSUM_EN
      TX_CK: if (tx_fire) begin
        state_d       = IDLE;
        brd_compute_d = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they track it exactly.
    rx_ready_d = (state_d == IDLE) || (state_d == RX_X1) || (state_d == RX_Y1) ||
                 (state_d == RX_X2) || (state_d == RX_Y2)
`ifdef MOVE_LINK_CHECKSUM_EN
                 || (state_d == RX_CK)
`endif
                 ;
    busy_d     = (state_d != IDLE);
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    case (state_d)
      TX_H: begin tx_valid_d = 1'b1; tx_data_d = TX_HDR;           end
      TX_X: begin tx_valid_d = 1'b1; tx_data_d = {2'b00, rep_x_q}; end
      TX_Y: begin tx_valid_d = 1'b1; tx_data_d = {2'b00, rep_y_q}; end
`ifdef MOVE_LINK_CHECKSUM_EN
      TX_CK: begin
        tx_valid_d = 1'b1;
        tx_data_d  = TX_HDR ^ {2'b00, rep_x_q} ^ {2'b00, rep_y_q};
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs; async reset drops any partial packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stg_x1_q      <= '0;
      stg_y1_q      <= '0;
      stg_x2_q      <= '0;
      stg_y2_q      <= '0;
      brd_x1_q      <= '0;
      brd_y1_q      <= '0;
      brd_x2_q      <= '0;
      brd_y2_q      <= '0;
      rep_x_q       <= '0;
      rep_y_q       <= '0;
      ck_q          <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rx_ready_q    <= 1'b0;
      brd_compute_q <= 1'b0;
      pkt_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stg_x1_q      <= stg_x1_d;
      stg_y1_q      <= stg_y1_d;
      stg_x2_q      <= stg_x2_d;
      stg_y2_q      <= stg_y2_d;
      brd_x1_q      <= brd_x1_d;
      brd_y1_q      <= brd_y1_d;
      brd_x2_q      <= brd_x2_d;
      brd_y2_q      <= brd_y2_d;
      rep_x_q       <= rep_x_d;
      rep_y_q       <= rep_y_d;
      ck_q          <= ck_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      rx_ready_q    <= rx_ready_d;
      brd_compute_q <= brd_compute_d;
      pkt_err_q     <= pkt_err_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign brd_x1      = brd_x1_q;
  assign brd_y1      = brd_y1_q;
  assign brd_x2      = brd_x2_q;
  assign brd_y2      = brd_y2_q;
  assign brd_compute = brd_compute_q;
  assign pkt_err     = pkt_err_q;
  assign busy        = busy_q;

endmodule
